// File: rtl/expect_checker_pkg.sv
// rtl/expect_checker_pkg.sv - shared types and default parameters for expect_checker
package expect_checker_pkg;
  localparam int DEF_WIDTH     = 32;
  localparam int DEF_ADDR_BITS = 6;
  localparam int DEF_TOL       = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/expect_mem.sv
// rtl/expect_mem.sv - single-port synchronous RAM holding expected words, 1-cycle read
module expect_mem #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 6
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [WIDTH-1:0]     wdata,
  output logic [WIDTH-1:0]     rdata
);
  logic [WIDTH-1:0] mem [0:(1<<ADDR_BITS)-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/expect_checker.sv
// rtl/expect_checker.sv - compares a stream of actual words against preloaded expected words
module expect_checker
  import expect_checker_pkg::*;
#(
  parameter int          WIDTH     = DEF_WIDTH,
  parameter int          ADDR_BITS = DEF_ADDR_BITS,
  parameter int unsigned TOL       = DEF_TOL
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_valid,
  input  logic [WIDTH-1:0]     load_data,
  input  logic                 start,
  input  logic [ADDR_BITS:0]   check_len,
  input  logic                 act_valid,
  input  logic [WIDTH-1:0]     act_data,
  output logic                 act_ready,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_BITS:0]   err_count,
  output logic                 err_flag,
  output logic [ADDR_BITS-1:0] first_err_addr
);
  localparam int                 DEPTH   = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] DEPTH_V = (ADDR_BITS+1)'(DEPTH);
  localparam logic [WIDTH:0]     TOL_V   = (WIDTH+1)'(TOL);

  state_t                 state, state_nx;
  logic [ADDR_BITS-1:0]   load_ptr, rd_ptr, cmp_addr, mem_addr;
  logic [ADDR_BITS:0]     run_len, acc_cnt;
  logic                   cmp_pending;
  logic [WIDTH-1:0]       act_q, exp_data;
  logic                   start_acc, load_acc, hs, mismatch;
  logic [WIDTH:0]         diff, diff_abs;

  assign start_acc = (state != CHECK) && start;
  assign load_acc  = (state != CHECK) && load_valid && !start;
  assign act_ready = (state == CHECK) && (acc_cnt < run_len);
  assign hs        = act_valid && act_ready;
  assign busy      = (state == CHECK);
  assign done      = (state == DONE);

  // Load and check never overlap, so one port serves both.
  assign mem_addr = (state == CHECK) ? rd_ptr : load_ptr;

  expect_mem #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) u_mem (
    .clk   (clk),
    .we    (load_acc),
    .addr  (mem_addr),
    .wdata (load_data),
    .rdata (exp_data)
  );

  // Sign-extend to WIDTH+1 so the difference can never overflow.
  assign diff     = {act_q[WIDTH-1], act_q} - {exp_data[WIDTH-1], exp_data};
  assign diff_abs = diff[WIDTH] ? -diff : diff;
  assign mismatch = cmp_pending && (diff_abs > TOL_V);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start) state_nx = CHECK;
      // acc_cnt reaches run_len the cycle the last compare runs
      CHECK:      if (acc_cnt == run_len) state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      load_ptr       <= '0;
      rd_ptr         <= '0;
      cmp_addr       <= '0;
      acc_cnt        <= '0;
      run_len        <= '0;
      cmp_pending    <= 1'b0;
      act_q          <= '0;
      err_count      <= '0;
      err_flag       <= 1'b0;
      first_err_addr <= '0;
    end else begin
      cmp_pending <= hs;
      if (hs) begin
        act_q    <= act_data;
        cmp_addr <= rd_ptr;
        rd_ptr   <= rd_ptr + ADDR_BITS'(1);
        acc_cnt  <= acc_cnt + (ADDR_BITS+1)'(1);
      end
      if (load_acc) load_ptr <= load_ptr + ADDR_BITS'(1);
      if (start_acc) begin
        load_ptr       <= '0;
        rd_ptr         <= '0;
        acc_cnt        <= '0;
        run_len        <= (check_len > DEPTH_V) ? DEPTH_V : check_len;
        err_count      <= '0;
        err_flag       <= 1'b0;
        first_err_addr <= '0;
      end else if (mismatch) begin
        err_count <= err_count + (ADDR_BITS+1)'(1);
        err_flag  <= 1'b1;
        if (!err_flag) first_err_addr <= cmp_addr;
      end
    end
  end
endmodule

// File: tb/tb_expect_checker.sv
// tb/tb_expect_checker.sv - scoreboard bench for expect_checker, TOL=0 and TOL=1 instances side by side
module tb_expect_checker;
  logic        clk = 0;
  logic        reset = 1;
  logic        load_valid = 0;
  logic [31:0] load_data = 0;
  logic        start = 0;
  logic [6:0]  check_len = 0;
  logic        act_valid = 0;
  logic [31:0] act_data = 0;

  logic       act_ready0, busy0, done0, err_flag0;
  logic [6:0] err_count0;
  logic [5:0] first_err_addr0;
  logic       act_ready1, busy1, done1, err_flag1;
  logic [6:0] err_count1;
  logic [5:0] first_err_addr1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int last_drive = 0;

  typedef struct {int cnt; bit flag; int addr; int cyc;} exp_t;
  exp_t q0[$];
  exp_t q1[$];
  logic done0_q = 0, done1_q = 0;

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (act_valid && act_ready0) hs_cnt <= hs_cnt + 1;
  end

  expect_checker #(.WIDTH(32), .ADDR_BITS(6), .TOL(0)) dut0 (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .start(start), .check_len(check_len), .act_valid(act_valid), .act_data(act_data),
    .act_ready(act_ready0), .busy(busy0), .done(done0), .err_count(err_count0),
    .err_flag(err_flag0), .first_err_addr(first_err_addr0));

  expect_checker #(.WIDTH(32), .ADDR_BITS(6), .TOL(1)) dut1 (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .start(start), .check_len(check_len), .act_valid(act_valid), .act_data(act_data),
    .act_ready(act_ready1), .busy(busy1), .done(done1), .err_count(err_count1),
    .err_flag(err_flag1), .first_err_addr(first_err_addr1));

  task automatic chk(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  // Monitor: each rising done pops one expected result per instance.
  always @(negedge clk) begin
    exp_t e;
    if (done0 && !done0_q) begin
      if (q0.size() == 0) chk("tol0_unexpected_done", 1, 0);
      else begin
        e = q0.pop_front();
        chk("tol0_err_count", err_count0, e.cnt);
        chk("tol0_err_flag", err_flag0, e.flag);
        if (e.flag) chk("tol0_first_err_addr", first_err_addr0, e.addr);
        chk("tol0_done_cycle", cyc, e.cyc);
      end
    end
    if (done1 && !done1_q) begin
      if (q1.size() == 0) chk("tol1_unexpected_done", 1, 0);
      else begin
        e = q1.pop_front();
        chk("tol1_err_count", err_count1, e.cnt);
        chk("tol1_err_flag", err_flag1, e.flag);
        if (e.flag) chk("tol1_first_err_addr", first_err_addr1, e.addr);
        chk("tol1_done_cycle", cyc, e.cyc);
      end
    end
    done0_q = done0;
    done1_q = done1;
  end

  task automatic idle();
    @(negedge clk);
    load_valid = 0; start = 0; act_valid = 0;
  endtask

  task automatic load(input logic [31:0] v);
    @(negedge clk);
    load_valid = 1; load_data = v; start = 0; act_valid = 0;
  endtask

  task automatic do_start(input int len);
    @(negedge clk);
    start = 1; check_len = 7'(len); load_valid = 0; act_valid = 0;
    last_drive = cyc;
    hs_cnt = 0;
  endtask

  task automatic send(input logic [31:0] v);
    bit ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      start = 0; load_valid = 0; act_valid = 1; act_data = v;
      if (act_ready0) begin ok = 1; last_drive = cyc; end
    end
    if (!ok) chk("act_ready_timeout", 0, 1);
  endtask

  task automatic push(input int c0, input bit f0, input int a0,
                      input int c1, input bit f1, input int a1);
    exp_t e;
    e.cyc = last_drive + 2;
    e.cnt = c0; e.flag = f0; e.addr = a0; q0.push_back(e);
    e.cnt = c1; e.flag = f1; e.addr = a1; q1.push_back(e);
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (done0 && done1) seen = 1;
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_busy"}, busy0 | busy1, 0);
    chk({tag, "_done"}, done0 | done1, 0);
    chk({tag, "_act_ready"}, act_ready0 | act_ready1, 0);
    chk({tag, "_err_count"}, err_count0 | err_count1, 0);
    chk({tag, "_err_flag"}, err_flag0 | err_flag1, 0);
    chk({tag, "_first_err_addr"}, first_err_addr0 | first_err_addr1, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_quiet("reset");
    reset = 0;

    // Exact match, then mismatches at TOL 0 and 1
    load(10); load(20); load(30); load(40);
    do_start(4); send(10); send(20); send(30); send(40);
    push(0, 0, 0, 0, 0, 0); idle(); wait_done();

    do_start(4); send(10); send(21); send(30); send(99);
    push(2, 1, 1, 1, 1, 3); idle(); wait_done();

    do_start(4); send(11); send(19); send(32); send(40);
    push(3, 1, 0, 1, 1, 2); idle(); wait_done();

    // Zero-length run: no act_ready, done two cycles after start
    do_start(0);
    push(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      start = 0; act_valid = 1; act_data = 5;
      chk("len0_act_ready", act_ready0 | act_ready1, 0);
    end
    idle(); wait_done();

    // Negative values: -5 vs -6
    load(32'hFFFF_FFFA);
    do_start(1); send(32'hFFFF_FFFB);
    push(1, 1, 0, 0, 0, 0); idle(); wait_done();

    // Reset mid-run with a mismatch in flight
    load(10); load(20); load(30); load(40);
    do_start(4); send(10); send(99);
    @(negedge clk);
    reset = 1; act_valid = 0;
    @(negedge clk);
    reset = 0;
    check_quiet("midreset");
    load(77);
    do_start(1); send(77);
    push(0, 0, 0, 0, 0, 0); idle(); wait_done();

    // 65 loads wrap the load pointer: address 0 ends up holding 64
    for (int i = 0; i <= 64; i++) load(32'(i));
    do_start(1); send(64);
    push(0, 0, 0, 0, 0, 0); idle(); wait_done();

    // Oversized length clamps to 64 words
    do_start(100);
    send(64);
    for (int i = 1; i < 64; i++) send(32'(i));
    push(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    act_valid = 1; act_data = 0;
    chk("len100_act_ready_after_64", act_ready0 | act_ready1, 0);
    idle(); wait_done();
    chk("len100_handshakes", hs_cnt, 64);

    idle(); idle();
    chk("scoreboard_tol0_empty", q0.size(), 0);
    chk("scoreboard_tol1_empty", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/expect_checker.md
EXPECT_CHECKER -- requirements
Module: expect_checker

Interface
- REQ-001: Parameter WIDTH, default 32, data word width in bits.
- REQ-002: Parameter ADDR_BITS, default 6, expected-memory address width; DEPTH = 2^ADDR_BITS.
- REQ-003: Parameter TOL, default 0, absolute mismatch tolerance in LSBs, unsigned.
- REQ-004: clk  input  1  sole clock; all logic on rising edge.
- REQ-005: reset  input  1  synchronous, active-high reset.
- REQ-006: load_valid  input  1  write load_data at the load pointer this cycle.
- REQ-007: load_data  input  WIDTH  expected value, two's complement.
- REQ-008: start  input  1  begin a check run of check_len words.
- REQ-009: check_len  input  ADDR_BITS+1  word count of the run, sampled on start.
- REQ-010: act_valid  input  1  actual-data valid.
- REQ-011: act_data  input  WIDTH  actual value, two's complement.
- REQ-012: act_ready  output  1  block accepts act_data this cycle.
- REQ-013: busy  output  1  high in CHECK.
- REQ-014: done  output  1  run complete, level.
- REQ-015: err_count  output  ADDR_BITS+1  mismatches in the current or last run.
- REQ-016: err_flag  output  1  at least one mismatch in the run.
- REQ-017: first_err_addr  output  ADDR_BITS  address of the first mismatch; meaningful only when err_flag=1.

Function
- REQ-018: FSM states are IDLE, CHECK and DONE.
- REQ-019: In IDLE or DONE, load_valid writes the memory at load_ptr, and load_ptr increments, wrapping from DEPTH-1 to 0.
- REQ-020: In IDLE or DONE, start moves the FSM to CHECK and clears err_count, err_flag, first_err_addr, rd_ptr and load_ptr; done falls in the same cycle.
- REQ-021: If start and load_valid coincide, start wins and the load is dropped.
- REQ-022: load_valid is ignored in CHECK.
- REQ-023: The run length is min(check_len, DEPTH); a length of 0 moves CHECK to DONE in the following cycle with err_count=0.
- REQ-024: act_ready=1 in CHECK while the number of accepted words is below the run length, and 0 otherwise.
- REQ-025: A handshake is act_valid&&act_ready; on a handshake the block issues a synchronous memory read at rd_ptr, registers act_data and rd_ptr, and increments rd_ptr.
- REQ-026: The compare occurs one cycle after the handshake; it is a mismatch when |act-exp| > TOL, with the difference formed signed in WIDTH+1 bits.
- REQ-027: On a mismatch, err_count increments and err_flag sets; first_err_addr captures the address only if err_flag was 0.
- REQ-028: When the last handshake is at cycle t, its compare is at t+1, and the FSM enters DONE at t+2 with done=1 and final counts.
- REQ-029: done holds until the next accepted start or reset.
- REQ-030: start is ignored in CHECK.
- REQ-031: act_valid is ignored outside CHECK.
- REQ-032: Back-to-back handshakes are sustained at 1 word/cycle with no bubbles.

Reset
- REQ-033: On reset the FSM enters IDLE, and load_ptr, rd_ptr, err_count, err_flag, first_err_addr, done, busy and act_ready are 0.
- REQ-034: Memory contents are not reset.
- REQ-035: Reset mid-CHECK discards the in-flight compare and takes effect in the next cycle.

Structure
- REQ-036: The FSM state encoding and the default parameter values belong in the shared types package.
- REQ-037: The single sub-module is expect_mem, a WIDTH x DEPTH synchronous single-port RAM with 1-cycle read latency; it is shared between load and check, which are mutually exclusive.

Verification (WIDTH=32, ADDR_BITS=6)
- REQ-038: Load 10,20,30,40; start with check_len=4; drive act 10,20,30,40 back-to-back -> done=1 at last handshake+2, err_count=0, err_flag=0.
- REQ-039: Same load, act 10,21,30,99, TOL=0 -> err_count=2, err_flag=1, first_err_addr=1.
- REQ-040: TOL=1, same load, act 11,19,32,40 -> err_count=1, first_err_addr=2; negative values -5 vs -6 -> no error.
- REQ-041: check_len=0 -> done=1 two cycles after start with act_ready never high; check_len=100 -> exactly 64 handshakes accepted, then act_ready=0.
- REQ-042: Reset after 2 of 4 handshakes -> next cycle IDLE, all outputs 0; a following load_valid writes address 0.
- REQ-043: 65 loads of value i -> address 0 holds 64; start with check_len=1 and act=64 -> err_count=0.
